carry_propagation_buffer: RTL and testbench

//  Byte-output stage directly downstream of arithmetic_encoder.

---
 rtl/carry_propagation_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_carry_propagation_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_propagation_buffer.sv
// Carry-resolving byte output stage: holds the newest unresolved byte plus a run of deferred 0xFF
// bytes and releases them once the carry into them is known. `CARRY_BUF_BYTE_COUNT_EN adds byte_count.
module carry_propagation_buffer #(
  parameter int unsigned RUN_CNT_WIDTH = 16
) (
  input  logic        general_clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_carry,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready,
  output logic        flush_done,
`ifdef CARRY_BUF_BYTE_COUNT_EN
  output logic [31:0] byte_count,
`endif
  output logic        err
);

  localparam logic [2:0] StEmpty    = 3'd0;
  localparam logic [2:0] StHold     = 3'd1;
  localparam logic [2:0] StOutPend  = 3'd2;
  localparam logic [2:0] StOutRun   = 3'd3;
  localparam logic [2:0] StDrainEnd = 3'd4;

  localparam logic [RUN_CNT_WIDTH-1:0] RunMax  = '1;
  localparam logic [RUN_CNT_WIDTH-1:0] RunOne  = RUN_CNT_WIDTH'(1);
  localparam logic [RUN_CNT_WIDTH-1:0] RunZero = '0;

  logic [2:0]               state_q, state_d;
  logic [7:0]               pend_q, pend_d;
  logic [RUN_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]               run_byte_q, run_byte_d;
  logic [7:0]               emit_q, emit_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     pend_held_q, pend_held_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_byte_q, out_byte_d;
  logic                     flush_done_q, flush_done_d;
  logic                     err_q, err_d;

  logic accept;
  logic seg_done;
  logic start_drain;

  assign in_ready   = !reset && ((state_q == StEmpty) || (state_q == StHold));
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign flush_done = flush_done_q;
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    run_cnt_d    = run_cnt_q;
    run_byte_d   = run_byte_q;
    emit_d       = emit_q;
    flush_pend_d = flush_pend_q;
    pend_held_d  = pend_held_q;
    flush_done_d = 1'b0;
    err_d        = err_q;
    seg_done     = 1'b0;
    start_drain  = 1'b0;

    case (state_q)
      StEmpty: begin
        if (accept) begin
          // Nothing is held, so a carry here has nowhere to go.
          if (in_carry) err_d = 1'b1;
          run_cnt_d = RunZero;
          if (flush) begin
            emit_d       = in_byte;
            run_byte_d   = 8'hFF;
            flush_pend_d = 1'b1;
            pend_held_d  = 1'b0;
            state_d      = StOutPend;
          end else begin
            pend_d  = in_byte;
            state_d = StHold;
          end
        end else if (flush) begin
          flush_done_d = 1'b1;
        end
      end

      StHold: begin
        if (accept) begin
          if (!in_carry && (in_byte == 8'hFF)) begin
            if (run_cnt_q == RunMax) begin
              err_d = 1'b1;
            end else begin
              run_cnt_d = run_cnt_q + RunOne;
            end
            start_drain = flush;
          end else begin
            // Carry resolves pend and the run; the new byte becomes the next pend.
            emit_d       = pend_q + {7'd0, in_carry};
            if (in_carry && (pend_q == 8'hFF)) err_d = 1'b1;
            run_byte_d   = in_carry ? 8'h00 : 8'hFF;
            pend_d       = in_byte;
            pend_held_d  = 1'b1;
            flush_pend_d = flush;
            state_d      = StOutPend;
          end
        end else if (flush) begin
          start_drain = 1'b1;
        end
      end

      StOutPend: begin
        if (out_ready) begin
          if (run_cnt_q != RunZero) begin
            state_d = StOutRun;
          end else begin
            seg_done = 1'b1;
          end
        end
      end

      StOutRun: begin
        if (out_ready) begin
          run_cnt_d = run_cnt_q - RunOne;
          if (run_cnt_q == RunOne) seg_done = 1'b1;
        end
      end

      StDrainEnd: begin
        flush_pend_d = 1'b0;
        state_d      = StEmpty;
      end

      default: begin
        state_d = StEmpty;
      end
    endcase

    if (seg_done) begin
      if (!flush_pend_q) begin
        state_d = StHold;
      end else if (pend_held_q) begin
        start_drain = 1'b1;
      end else begin
        state_d = StDrainEnd;
      end
    end

    // A drain emits the still-held pend followed by its (unresolved, hence 0xFF) run.
    if (start_drain) begin
      emit_d       = pend_q;
      run_byte_d   = 8'hFF;
      flush_pend_d = 1'b1;
      pend_held_d  = 1'b0;
      state_d      = StOutPend;
    end

    if (state_d == StDrainEnd) flush_done_d = 1'b1;

    out_valid_d = (state_d == StOutPend) || (state_d == StOutRun);
    if (state_d == StOutPend) begin
      out_byte_d = emit_d;
    end else if (state_d == StOutRun) begin
      out_byte_d = run_byte_d;
    end else begin
      out_byte_d = out_byte_q;
    end
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      pend_q       <= 8'h00;
      run_cnt_q    <= RunZero;
      run_byte_q   <= 8'h00;
      emit_q       <= 8'h00;
      flush_pend_q <= 1'b0;
      pend_held_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      run_cnt_q    <= run_cnt_d;
      run_byte_q   <= run_byte_d;
      emit_q       <= emit_d;
      flush_pend_q <= flush_pend_d;
      pend_held_q  <= pend_held_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

`ifdef CARRY_BUF_BYTE_COUNT_EN
  logic [31:0] byte_count_q;

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      byte_count_q <= 32'd0;
    end else if (out_valid_q && out_ready) begin
      byte_count_q <= byte_count_q + 32'd1;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_carry_propagation_buffer.sv
// Bench for carry_propagation_buffer: directed scenarios plus random traffic, all checked against
// a byte-queue model that resolves carries by big-endian addition over the held bytes.
module tb_carry_propagation_buffer;

  localparam int RUN_MAX = 65535;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_carry;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready;
  logic        flush_done;
  logic        err;
`ifdef CARRY_BUF_BYTE_COUNT_EN
  logic [31:0] byte_count;
  logic [31:0] s_byte_count;
`endif

  logic        s_reset;
  logic        s_in_valid;
  logic [7:0]  s_in_byte;
  logic        s_in_carry;
  logic        s_in_ready;
  logic        s_flush;
  logic        s_out_valid;
  logic [7:0]  s_out_byte;
  logic        s_out_ready;
  logic        s_flush_done;
  logic        s_err;

  carry_propagation_buffer #(.RUN_CNT_WIDTH(16)) dut (
    .general_clk(clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_carry   (in_carry),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_ready  (out_ready),
    .flush_done (flush_done),
`ifdef CARRY_BUF_BYTE_COUNT_EN
    .byte_count (byte_count),
`endif
    .err        (err)
  );

  // Narrow run counter so saturation is reachable in a few cycles.
  carry_propagation_buffer #(.RUN_CNT_WIDTH(2)) dut_small (
    .general_clk(clk),
    .reset      (s_reset),
    .in_valid   (s_in_valid),
    .in_byte    (s_in_byte),
    .in_carry   (s_in_carry),
    .in_ready   (s_in_ready),
    .flush      (s_flush),
    .out_valid  (s_out_valid),
    .out_byte   (s_out_byte),
    .out_ready  (s_out_ready),
    .flush_done (s_flush_done),
`ifdef CARRY_BUF_BYTE_COUNT_EN
    .byte_count (s_byte_count),
`endif
    .err        (s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_hold[$];
  logic [7:0]  m_out[$];
  logic        m_err;
  logic        m_flush_wait;
  logic        m_done_pulse;
  logic        m_drain_end;
  logic [31:0] m_count;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold.delete();
    m_out.delete();
    m_err        = 1'b0;
    m_flush_wait = 1'b0;
    m_done_pulse = 1'b0;
    m_drain_end  = 1'b0;
    m_count      = 32'd0;
  endtask

  // Held bytes form a big-endian number; a carry is added to it and all of it becomes final.
  task automatic model_in(input logic [7:0] b, input logic c);
    logic [8:0] sum;
    logic       cy;
    if (m_hold.size() == 0) begin
      if (c) m_err = 1'b1;
      m_hold.push_back(b);
    end else if (!c && (b == 8'hFF)) begin
      if (m_hold.size() - 1 >= RUN_MAX) m_err = 1'b1;
      else m_hold.push_back(8'hFF);
    end else begin
      cy = c;
      for (int i = m_hold.size() - 1; i >= 0; i--) begin
        sum       = {1'b0, m_hold[i]} + {8'd0, cy};
        m_hold[i] = sum[7:0];
        cy        = sum[8];
      end
      if (cy) m_err = 1'b1;
      foreach (m_hold[i]) m_out.push_back(m_hold[i]);
      m_hold.delete();
      m_hold.push_back(b);
    end
  endtask

  // One clock: check the current outputs, drive new inputs, advance the model across the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic c, input logic f,
                      input logic ordy);
    logic exp_ir, exp_ov, nd_pulse, nd_drain;
    @(negedge clk);
    exp_ov = (m_out.size() != 0);
    exp_ir = !exp_ov && !m_drain_end;
    check_eq("in_ready", in_ready, exp_ir);
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("flush_done", flush_done, m_done_pulse);
    check_eq("err", err, m_err);
    if (exp_ov) check_eq("out_byte", out_byte, m_out[0]);
`ifdef CARRY_BUF_BYTE_COUNT_EN
    check_eq("byte_count", byte_count, m_count);
`endif
    in_valid  = v;
    in_byte   = b;
    in_carry  = c;
    flush     = f;
    out_ready = ordy;
    nd_pulse  = 1'b0;
    nd_drain  = 1'b0;
    if (exp_ov && ordy) begin
      void'(m_out.pop_front());
      m_count++;
      if ((m_out.size() == 0) && m_flush_wait) begin
        nd_pulse     = 1'b1;
        nd_drain     = 1'b1;
        m_flush_wait = 1'b0;
      end
    end
    if (exp_ir) begin
      if (v) model_in(b, c);
      if (f) begin
        if (m_hold.size() == 0) begin
          nd_pulse = 1'b1;
        end else begin
          foreach (m_hold[i]) m_out.push_back(m_hold[i]);
          m_hold.delete();
          m_flush_wait = 1'b1;
        end
      end
    end
    @(posedge clk);
    m_done_pulse = nd_pulse;
    m_drain_end  = nd_drain;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_carry  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_byte", out_byte, 8'h00);
    check_eq("rst_flush_done", flush_done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic       v, c, f, ordy;
    logic [7:0] b;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_byte     = 8'h00;
    in_carry    = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    s_reset     = 1'b1;
    s_in_valid  = 1'b0;
    s_in_byte   = 8'h00;
    s_in_carry  = 1'b0;
    s_flush     = 1'b0;
    s_out_ready = 1'b0;
    model_reset();

    do_reset();

    // Two plain bytes: first is released, second stays held.
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t1_out_byte", out_byte, 8'h12);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t1_in_ready", in_ready, 1'b1);

    // Carry through a 0xFF run with a 5-cycle stall on the first output.
    do_reset();
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t4_out_byte", out_byte, 8'h13);
    check_eq("t4_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Flush drains pend and its run, then pulses flush_done.
    do_reset();
    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    #1 check_eq("t3_last_byte", out_byte, 8'h07);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 check_eq("t3_flush_done", flush_done, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1 check_eq("empty_flush_done", flush_done, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Carry on the first byte is an error; then reset lands in the middle of a run.
    do_reset();
    step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 check_eq("t5_err_sticky", err, 1'b1);
    check_eq("t6_in_run", out_byte, 8'h00);
    do_reset();
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check_eq("t6_hold_ready", in_ready, 1'b1);
    check_eq("t6_hold_valid", out_valid, 1'b0);

    // Random traffic; error-provoking carries only in odd phases.
    for (int phase = 0; phase < 6; phase++) begin
      do_reset();
      for (int n = 0; n < 400; n++) begin
        v    = $urandom_range(0, 99) < 70;
        b    = ($urandom_range(0, 99) < 35) ? 8'hFF : 8'($urandom);
        c    = $urandom_range(0, 99) < 20;
        if ((phase % 2 == 0) && ((m_hold.size() == 0) || (m_hold[0] == 8'hFF))) c = 1'b0;
        f    = $urandom_range(0, 99) < 4;
        ordy = $urandom_range(0, 99) < 70;
        step(v, b, c, f, ordy);
      end
      for (int n = 0; n < 20; n++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // Run-counter saturation on the 2-bit instance.
    @(negedge clk);
    s_reset = 1'b0;
    s_in_valid = 1'b1;
    s_in_byte  = 8'h10;
    @(negedge clk);
    s_in_byte = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("sat_err_before", s_err, 1'b0);
    check_eq("sat_in_ready", s_in_ready, 1'b1);
    @(negedge clk);
    check_eq("sat_err_after", s_err, 1'b1);
    s_in_byte = 8'h01;
    @(negedge clk);
    s_in_valid = 1'b0;
    check_eq("sat_out_valid", s_out_valid, 1'b1);
    check_eq("sat_first_byte", s_out_byte, 8'h10);
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("sat_run_byte", s_out_byte, 8'hFF);
    end
    @(negedge clk);
    check_eq("sat_run_len", s_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
